// File: rtl/rv32i_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_ctrl_pkg
// Shared types and constants for the rv32i multicycle controller:
//   - state_t        : main FSM states
//   - alu_src_a_t / alu_src_b_t / res_src_t / adr_src_t / imm_src_t :
//                      datapath mux select encodings
//   - alu_control_t  : ALU operation codes
//   - OP_* / F3_*    : opcode and branch funct3 constants
//   - decode_imm_src / decode_alu_op : combinational field decoders
// -----------------------------------------------------------------------------
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_CALC,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_REG_A  = 2'd2,
        SRC_A_ZERO   = 2'd3
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_REG_B = 2'd0,
        SRC_B_IMM   = 2'd1,
        SRC_B_FOUR  = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'd0,
        RES_DATA       = 2'd1,
        RES_ALU_RESULT = 2'd2
    } res_src_t;

    typedef enum logic {
        ADR_PC     = 1'b0,
        ADR_RESULT = 1'b1
    } adr_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_control_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Immediate format from opcode; anything unrecognised falls back to I.
    function automatic imm_src_t decode_imm_src(input logic [6:0] op);
        imm_src_t imm;
        imm = IMM_I;
        case (op)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

    // funct3/funct7b5 -> ALU op. For I-type, instr[30] is part of the
    // immediate on ADDI, so SUB is only chosen for R-type.
    function automatic alu_control_t decode_alu_op(input logic [2:0] funct3,
                                                   input logic       funct7b5,
                                                   input logic       is_r);
        alu_control_t alu;
        alu = ALU_ADD;
        case (funct3)
            3'b000:  alu = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu = ALU_SLL;
            3'b010:  alu = ALU_SLT;
            3'b011:  alu = ALU_SLTU;
            3'b100:  alu = ALU_XOR;
            3'b101:  alu = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu = ALU_OR;
            default: alu = ALU_AND;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/rv32i_multicycle_controller_branch.sv
// -----------------------------------------------------------------------------
// rv32i_branch_unit
// Combinational branch condition evaluation.
// Ports:
//   funct3 (in, 3) : branch type
//   equal  (in, 1) : a == b
//   lt     (in, 1) : signed a < b
//   ltu    (in, 1) : unsigned a < b
//   taken  (out,1) : branch condition satisfied (funct3 010/011 never taken)
// -----------------------------------------------------------------------------
module rv32i_branch_unit
    import rv32i_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       equal,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = equal;
            F3_BNE:  taken = ~equal;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// -----------------------------------------------------------------------------
// rv32i_multicycle_controller
// Main control FSM plus ALU/immediate decode for the rv32i multicycle datapath.
// Parameter:
//   RESET_STATE_FETCH : 1 -> leave reset in S_FETCH, 0 -> in S_IDLE
// Build option:
//   RV32I_CTRL_ILLEGAL_TRAP_EN : when defined S_ILLEGAL is terminal and drives
//   the sticky illegal flag; otherwise S_ILLEGAL is a one-cycle NOP and
//   illegal is tied low.
// Ports:
//   clk, rst (sync, active-high), ena (step enable)
//   op, funct3, funct7b5        : latched instruction fields
//   equal, lt, ltu              : ALU comparison flags
//   pc_write, ir_write, mem_write, reg_write : write enables
//   adr_src, alu_src_a, alu_src_b, res_src, imm_src : mux selects
//   alu_control                 : ALU operation
//   illegal                     : sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module rv32i_multicycle_controller
    import rv32i_ctrl_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  logic         equal,
    input  logic         lt,
    input  logic         ltu,
    output logic         pc_write,
    output logic         ir_write,
    output logic         mem_write,
    output logic         reg_write,
    output logic         adr_src,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   res_src,
    output logic [2:0]   imm_src,
    output alu_control_t alu_control,
    output logic         illegal
);

    state_t state_reg;
    state_t state_next;

    logic         taken;
    logic         pc_write_st;
    logic         ir_write_st;
    logic         mem_write_st;
    logic         reg_write_st;
    adr_src_t     adr_st;
    alu_src_a_t   src_a_st;
    alu_src_b_t   src_b_st;
    res_src_t     res_st;
    alu_control_t alu_st;

    rv32i_branch_unit u_branch (
        .funct3 (funct3),
        .equal  (equal),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; ena=0 freezes the FSM in place.
    always_comb begin
        state_next = state_reg;
        if (ena) begin
            case (state_reg)
                S_IDLE:   state_next = S_FETCH;
                S_FETCH:  state_next = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_R:              state_next = S_EXEC_R;
                        OP_I:              state_next = S_EXEC_I;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR_CALC;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default:           state_next = S_ILLEGAL;
                    endcase
                end
                S_MEMADR:    state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:   state_next = S_MEMWB;
                S_MEMWB:     state_next = S_FETCH;
                S_MEMWRITE:  state_next = S_FETCH;
                S_EXEC_R:    state_next = S_ALUWB;
                S_EXEC_I:    state_next = S_ALUWB;
                S_ALUWB:     state_next = S_FETCH;
                S_BRANCH:    state_next = S_FETCH;
                S_JAL:       state_next = S_ALUWB;
                S_JALR_CALC: state_next = S_JAL;
                S_LUI:       state_next = S_ALUWB;
                S_AUIPC:     state_next = S_ALUWB;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
                S_ILLEGAL:   state_next = S_ILLEGAL;
`else
                S_ILLEGAL:   state_next = S_FETCH;
`endif
                default:     state_next = S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls, before ena/rst gating.
    always_comb begin
        pc_write_st  = 1'b0;
        ir_write_st  = 1'b0;
        mem_write_st = 1'b0;
        reg_write_st = 1'b0;
        adr_st       = ADR_PC;
        src_a_st     = SRC_A_PC;
        src_b_st     = SRC_B_REG_B;
        res_st       = RES_ALU_OUT;
        alu_st       = ALU_ADD;
        case (state_reg)
            S_FETCH: begin
                ir_write_st = 1'b1;
                pc_write_st = 1'b1;
                src_a_st    = SRC_A_PC;
                src_b_st    = SRC_B_FOUR;
                res_st      = RES_ALU_RESULT;
            end
            S_DECODE: begin
                src_a_st = SRC_A_OLD_PC;
                src_b_st = SRC_B_IMM;
            end
            S_MEMADR: begin
                src_a_st = SRC_A_REG_A;
                src_b_st = SRC_B_IMM;
            end
            S_MEMREAD: begin
                adr_st = ADR_RESULT;
                res_st = RES_ALU_OUT;
            end
            S_MEMWB: begin
                res_st       = RES_DATA;
                reg_write_st = 1'b1;
            end
            S_MEMWRITE: begin
                adr_st       = ADR_RESULT;
                res_st       = RES_ALU_OUT;
                mem_write_st = 1'b1;
            end
            S_EXEC_R: begin
                src_a_st = SRC_A_REG_A;
                src_b_st = SRC_B_REG_B;
                alu_st   = decode_alu_op(funct3, funct7b5, 1'b1);
            end
            S_EXEC_I: begin
                src_a_st = SRC_A_REG_A;
                src_b_st = SRC_B_IMM;
                alu_st   = decode_alu_op(funct3, funct7b5, 1'b0);
            end
            S_ALUWB: begin
                res_st       = RES_ALU_OUT;
                reg_write_st = 1'b1;
            end
            S_BRANCH: begin
                src_a_st    = SRC_A_REG_A;
                src_b_st    = SRC_B_REG_B;
                alu_st      = ALU_SUB;
                res_st      = RES_ALU_OUT;
                // Only Mealy output: the target computed in DECODE sits in
                // ALU_OUT, loaded into PC only when the condition holds.
                pc_write_st = taken;
            end
            S_JAL: begin
                src_a_st    = SRC_A_OLD_PC;
                src_b_st    = SRC_B_FOUR;
                res_st      = RES_ALU_OUT;
                pc_write_st = 1'b1;
            end
            S_JALR_CALC: begin
                src_a_st = SRC_A_REG_A;
                src_b_st = SRC_B_IMM;
            end
            S_LUI: begin
                src_a_st = SRC_A_ZERO;
                src_b_st = SRC_B_IMM;
            end
            S_AUIPC: begin
                src_a_st = SRC_A_OLD_PC;
                src_b_st = SRC_B_IMM;
            end
            default: begin
            end
        endcase
    end

    // Write enables need a live step and no reset; selects only blank in reset.
    assign pc_write    = pc_write_st  & ena & ~rst;
    assign ir_write    = ir_write_st  & ena & ~rst;
    assign mem_write   = mem_write_st & ena & ~rst;
    assign reg_write   = reg_write_st & ena & ~rst;
    assign adr_src     = rst ? 1'b0 : adr_st;
    assign alu_src_a   = rst ? 2'd0 : src_a_st;
    assign alu_src_b   = rst ? 2'd0 : src_b_st;
    assign res_src     = rst ? 2'd0 : res_st;
    assign imm_src     = rst ? 3'd0 : decode_imm_src(op);
    assign alu_control = rst ? ALU_ADD : alu_st;

`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    // S_ILLEGAL is terminal until reset, so the state itself is the sticky flag.
    assign illegal = (state_reg == S_ILLEGAL) & ~rst;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/rv32i_multicycle_controller.md
Name: rv32i_multicycle_controller

Overview:
- Main control FSM plus ALU/immediate decode that drives the rv32i multicycle datapath. It sits directly upstream of the datapath.
- Inputs: the latched instruction fields and the ALU comparison flags.
- Outputs: every mux select and write enable for one step per clock.
- Each instruction takes 3–5 cycles, following the classic FETCH/DECODE/execute/writeback multicycle flow.

Parameters:
- RESET_STATE_FETCH, 1, when 1 the FSM leaves reset in S_FETCH; when 0 it leaves reset in S_IDLE and waits one ena cycle before fetch.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; synchronous, active-high
- ena  input  1  step enable; when low the FSM holds state and all write enables are 0
- op  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- equal  input  1  ALU a==b
- lt  input  1  signed a<b, from datapath
- ltu  input  1  unsigned a<b
- pc_write  output  1  PC/PC_old register enable
- ir_write  output  1  instruction register enable
- mem_write  output  1  data memory write enable
- reg_write  output  1  register file write enable
- adr_src  output  1  0 = PC, 1 = result
- alu_src_a  output  2  0 = PC, 1 = OLD_PC, 2 = REG_A, 3 = ZERO
- alu_src_b  output  2  0 = REG_B, 1 = IMM, 2 = FOUR
- res_src  output  2  0 = ALU_OUT, 1 = DATA, 2 = ALU_RESULT
- imm_src  output  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- alu_control  output  alu_control_t  ALU operation
- illegal  output  1  sticky illegal-opcode flag (feature-gated)

Behaviour:
- Reset: state register only; takes effect on the rising edge while rst=1. Next state is S_FETCH (or S_IDLE per parameter).
- While rst=1, all enables and selects are 0 and illegal=0. Reset mid-instruction abandons the instruction; no write enable fires in the reset cycle.
- Outputs are Moore, decoded from state, with one exception: pc_write in S_BRANCH is Mealy on the flags.
- imm_src and alu_control are combinational from op/funct3/funct7b5. Unknown opcode gives imm_src=0.
- ena=0: state holds and pc_write/ir_write/mem_write/reg_write=0. Selects still reflect the current state.
- States and actions (ALU add unless noted):
  - S_FETCH: adr_src=0, ir_write, a=PC, b=FOUR, res=ALU_RESULT, pc_write → S_DECODE.
  - S_DECODE: a=OLD_PC, b=IMM (branch/jal target into ALU_OUT). Next by op:
    - 0000011/0100011 → S_MEMADR
    - 0110011 → S_EXEC_R
    - 0010011 → S_EXEC_I
    - 1100011 → S_BRANCH
    - 1101111 → S_JAL
    - 1100111 → S_JALR_CALC
    - 0110111 → S_LUI
    - 0010111 → S_AUIPC
    - else → S_ILLEGAL
  - S_MEMADR: a=REG_A, b=IMM → S_MEMREAD (load) or S_MEMWRITE (store).
  - S_MEMREAD: adr_src=1, res=ALU_OUT → S_MEMWB.
  - S_MEMWB: res=DATA, reg_write → S_FETCH.
  - S_MEMWRITE: adr_src=1, res=ALU_OUT, mem_write → S_FETCH.
  - S_EXEC_R: a=REG_A, b=REG_B, funct-decoded op → S_ALUWB.
  - S_EXEC_I: a=REG_A, b=IMM, funct-decoded op (SUB never chosen for I-type) → S_ALUWB.
  - S_ALUWB: res=ALU_OUT, reg_write → S_FETCH.
  - S_BRANCH: a=REG_A, b=REG_B, SUB, res=ALU_OUT.
    - pc_write = taken, where taken is: funct3 000 equal; 001 !equal; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never.
    - → S_FETCH.
  - S_JAL: a=OLD_PC, b=FOUR, res=ALU_OUT, pc_write → S_ALUWB.
  - S_JALR_CALC: a=REG_A, b=IMM → S_JAL (target then sits in ALU_OUT).
  - S_LUI: a=ZERO, b=IMM → S_ALUWB.
  - S_AUIPC: a=OLD_PC, b=IMM → S_ALUWB.
- Latency:
  - branch 3
  - store, R-type, I-type, jal, lui, auipc 4
  - load, jalr 5

Optional Feature:
- Macro: RV32I_CTRL_ILLEGAL_TRAP_EN.
- Defined: S_ILLEGAL is terminal. It asserts illegal=1 (sticky until rst) with all write enables 0, and the FSM stays until reset.
- Undefined: S_ILLEGAL goes to S_FETCH next cycle with no writes (NOP), and illegal is tied 0.

Decomposition:
- Shared package rv32i_ctrl_pkg holds:
  - state enum
  - alu_src_a/b, res_src, adr_src, imm_src enums with the encodings above
  - opcode constants
- One natural combinational sub-module: rv32i_branch_unit (funct3, equal, lt, ltu → taken).

Test Plan:
- add x3,x1,x2 (0x002081B3) → states FETCH, DECODE, EXEC_R, ALUWB, FETCH; reg_write only in ALUWB; alu_control=ADD.
- lw x3,0(x1) (0x0000A183) → 5 cycles; adr_src=1 in MEMREAD; res_src=DATA with reg_write in MEMWB.
- beq x0,x0 (0x00000063) with equal=1 → pc_write in BRANCH. Same with 0x00001063 (bne) and equal=1 → no pc_write; 3 cycles either way.
- jalr x1,0(x2) (0x000100E7) → DECODE, JALR_CALC, JAL (pc_write, res=ALU_OUT), ALUWB (reg_write).
- ena=0 for 3 cycles in S_EXEC_R → state holds and no write enables. With ena=1, rst asserted in S_MEMWRITE → no mem_write that cycle and S_FETCH next.
- Opcode 0x0000007F → with the macro, illegal=1 and the FSM stays put; without it, back to FETCH after 3 cycles with no writes.
